output_cache: RTL
=================

OUTPUT_CACHE -- requirements
Module: output_cache

Interface
REQ-001 Parameter A, default 60000: number of row entries in the cache.
REQ-002 Parameter N, default 256: 32-bit words per row.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 row_in  input  32 x [N-1:0] unpacked  full result row to store.
REQ-006 row_valid  input  1  write request for row_in.
REQ-007 row_sel_a  input  16  destination row index for write.
REQ-008 drain_start  input  1  request to stream rows out word-serially.
REQ-009 drain_rows  input  16  number of rows to stream, starting at row 0.
REQ-010 data_out  output  32  current streamed word.
REQ-011 out_valid  output  1  data_out holds a valid word.
REQ-012 out_ready  input  1  downstream accepts data_out.
REQ-013 busy  output  1  high while in DRAIN.
REQ-014 done  output  1  one-cycle pulse at drain completion.
REQ-015 wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-016 FSM states: IDLE, DRAIN; only IDLE accepts writes or drain_start.
REQ-017 IDLE, row_valid=1, row_sel_a<A: all N words of row_in stored to row row_sel_a at that edge.
REQ-018 row_valid=1 with row_sel_a>=A, or row_valid=1 while busy: no memory change; wr_err=1 next cycle for one cycle.
REQ-019 IDLE, drain_start=1, drain_rows>=1: latch count=min(drain_rows,A), row idx=0, col idx=0, enter DRAIN; busy=1 next cycle.
REQ-020 IDLE, drain_start=1, drain_rows=0: stay IDLE; done=1 next cycle for one cycle; out_valid stays 0.
REQ-021 drain_start while busy: ignored, no effect on count or indices.
REQ-022 First out_valid=1 exactly one cycle after drain_start accepted; data_out = mem[0][0].
REQ-023 Word order: row r, col 0..N-1, then row r+1; col wraps N-1 -> 0 with row increment.
REQ-024 Handshake: word transfers on cycle with out_valid=1 and out_ready=1; next word presented next cycle (full throughput, one word/cycle when out_ready held high).
REQ-025 out_valid=1 and out_ready=0: data_out and out_valid held stable; out_valid never drops without a transfer.
REQ-026 Transfer of last word (row count-1, col N-1): next cycle out_valid=0, busy=0, done=1 for one cycle, state IDLE.
REQ-027 Same-cycle row_valid and accepted drain_start in IDLE: write performed; streamed data reflects the written row.
REQ-028 Memory read port row-wide or word-wide is implementation choice; externally visible timing per REQ-022..026 is fixed.
REQ-029 done and wr_err never asserted longer than one cycle per event.

Reset
REQ-030 rst=1: next cycle state=IDLE, out_valid=0, busy=0, done=0, wr_err=0, data_out=0, indices and count cleared.
REQ-031 rst mid-drain aborts stream; no done pulse; remaining words discarded.
REQ-032 Memory contents not cleared by rst; read-before-write contents undefined.
REQ-033 rst has priority over row_valid and drain_start in the same cycle.

Verification (bench A=8, N=4)
REQ-034 Write rows 0,1 with words {0x10..0x13},{0x20..0x23}; drain_rows=2, out_ready=1 -> out_valid 8 consecutive cycles, data 0x10,0x11,0x12,0x13,0x20,0x21,0x22,0x23; done 1 cycle after last; busy low.
REQ-035 Same drain, out_ready toggling 1,0,1,0 -> each word held stable while out_ready=0; same 8-word sequence, no duplicates or drops.
REQ-036 row_valid with row_sel_a=8 -> wr_err pulse next cycle, drain of 8 rows shows no changed row; row_valid during DRAIN -> wr_err pulse, memory unchanged.
REQ-037 drain_rows=0 -> done pulse next cycle, out_valid never 1; drain_rows=20 -> exactly 32 words transferred (clamped to A=8).
REQ-038 rst asserted after 3rd transfer of 8-word drain -> next cycle out_valid=0, busy=0, no done; new drain_rows=1 then yields 0x10..0x13 (memory retained).
REQ-039 drain_start pulse while busy -> stream length and order unchanged.

Source files
------------

// File: rtl/output_cache.sv
// Row-addressed result cache: whole rows are written in one cycle and later
// streamed out word-serially over a valid/ready handshake.
module output_cache #(
  parameter int A = 60000,
  parameter int N = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_row_in [N],
  input  logic        i_row_valid,
  input  logic [15:0] i_row_sel_a,
  input  logic        i_drain_start,
  input  logic [15:0] i_drain_rows,
  output logic [31:0] o_data_out,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_wr_err
);

  localparam int RW = (A > 1) ? $clog2(A) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [16:0] ROWS = 17'(A);
  localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_row;
  logic [15:0]   w_row_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_col_nxt;
  logic [15:0]   r_count;
  logic [15:0]   w_count_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_wr_err;
  logic          w_wr_err_nxt;

  logic [31:0]   r_mem [A][N];

  logic          w_wr_ok;
  logic          w_mem_we;
  logic [15:0]   w_count_clamped;

  assign w_wr_ok  = i_row_valid && (r_state == IDLE) && ({1'b0, i_row_sel_a} < ROWS);
  assign w_mem_we = w_wr_ok && !i_rst;
  assign w_count_clamped = ({1'b0, i_drain_rows} > ROWS) ? ROWS[15:0] : i_drain_rows;

  // Read is combinational from the index registers, so a row written on the
  // same edge a drain is accepted is already visible on the first word.
  assign o_data_out  = (r_state == DRAIN) ? r_mem[r_row[RW-1:0]][r_col] : 32'd0;
  assign o_out_valid = (r_state == DRAIN);
  assign o_busy      = (r_state == DRAIN);
  assign o_done      = r_done;
  assign o_wr_err    = r_wr_err;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int j = 0; j < N; j++) begin
        r_mem[i_row_sel_a[RW-1:0]][j] <= i_row_in[j];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;
    w_wr_err_nxt = i_row_valid && !w_wr_ok;

    case (r_state)
      IDLE: begin
        if (i_drain_start) begin
          if (i_drain_rows == 16'd0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_count_nxt = w_count_clamped;
            w_row_nxt   = 16'd0;
            w_col_nxt   = '0;
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (i_out_ready) begin
          if (r_col == LAST_COL) begin
            w_col_nxt = '0;
            if (r_row == r_count - 16'd1) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
              w_row_nxt   = 16'd0;
              w_count_nxt = 16'd0;
            end else begin
              w_row_nxt = r_row + 16'd1;
            end
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_row    <= 16'd0;
      r_col    <= '0;
      r_count  <= 16'd0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_count  <= w_count_nxt;
      r_done   <= w_done_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

endmodule
